dynamic_lighting_driver: RTL and testbench
==========================================

# dynamic_lighting_driver

Downstream consumer of the 2-bit digit-select produced by the dynamic-lighting clock divider. Drives a 4-digit, common-anode 7-segment display by multiplexing one digit at a time. Provides ghost-suppression blanking on every digit change, double-buffered display data committed only at frame boundaries, and optional leading-zero suppression. Output pins go straight to the board display.

## Interface
- `BLANK_CYC`, 16: blank cycles inserted after every digit-select change; legal range 1..255.
- `LZS`, 1: 1 = leading-zero suppression on; 0 = all enabled digits lit.
- `CLK` input 1: system clock, same domain as the divider.
- `RST_N` input 1: reset, asynchronous and active-low.
- `SEL` input 2: digit select from the divider. Synchronous to `CLK`, changes at most once per many cycles.
- `LOAD` input 1: one-cycle strobe that captures `DATA`, `DP_IN` and `EN_IN` into the pending buffer.
- `DATA` input 16: four hex nibbles; digit *n* = `DATA[4n+3:4n]`.
- `DP_IN` input 4: decimal-point request per digit, 1 = lit.
- `EN_IN` input 4: digit enable, 0 = digit always dark.
- `AN` output 4: anodes, active-low; at most one bit low.
- `SEG` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `DP` output 1: decimal point, active-low.
- `BUSY` output 1: pending buffer holds data not yet committed.

## Operation
- `sel_q` registers `SEL` every cycle. A change is detected on any edge where `SEL != sel_q`.
- FSM states:
  - BLANK: all outputs dark.
  - SHOW: digit `cur` lit.
- Transitions:
  - Change detected in either state: go to BLANK, load `cnt` with 0, load `cur` with `SEL`.
  - In BLANK, `cnt` increments each cycle. When `cnt == BLANK_CYC-1`, go to SHOW.
  - A change arriving during BLANK restarts the blank period with the new digit.
- Output registers, updated every edge from the next-state values:
  - Dark: `AN=4'hF`, `SEG=7'h7F`, `DP=1`.
  - SHOW: `AN = ~(1<<cur)`, `SEG` = decode of the active nibble, `DP = ~dp_act[cur]`.
  - A SHOW digit with `en_act[cur]==0` drives `AN=4'hF` (fully dark).
- Hex decode:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero suppression (`LZS=1`):
  - Digit *n* (n=3..1) is suppressed when its nibble and all higher nibbles are 0. A suppressed digit shows `SEG=7'h7F`, but its anode and `DP` behave as normal.
  - Digit 0 is never suppressed.
- Double buffer:
  - `LOAD` writes the pending registers and sets `BUSY`.
  - Commit (pending to active, `BUSY` cleared) happens on the edge where a change to `SEL==0` is detected.
  - `LOAD` on the same edge as a commit: commit takes the pre-edge pending contents; the new data lands in pending and `BUSY` stays 1.
  - Back-to-back `LOAD`s: the last one wins.

## Timing
- Reset values (asynchronous): `AN=4'hF`, `SEG=7'h7F`, `DP=1`, `BUSY=0`, active/pending data=0, active `EN=4'hF`, active `DP=0`, `sel_q=0`, `cur=0`, state=BLANK, `cnt=0`.
- From reset release with `SEL=0`: `AN=4'b1110` and `SEG=7'h40` first appear after edge `BLANK_CYC`.
- Change sampled at edge *k*:
  - Outputs are dark after edge *k*.
  - The new digit is lit after edge *k+BLANK_CYC*.
  - So exactly `BLANK_CYC` dark cycles.
- `LOAD` to `BUSY=1`: 1 cycle. `BUSY` falls on the commit edge.
- New data is visible no later than one full frame plus `BLANK_CYC` cycles after the commit.
- `RST_N` asserted mid-frame: outputs go dark immediately, and pending data is discarded.

## Structure
- Package `seg7_pkg`:
  - `SEG_BLANK=7'h7F`, `AN_OFF=4'hF`
  - 16-entry hex pattern constants
  - FSM state typedef (BLANK, SHOW)
- Sub-module `seg7_decode`: combinational, 4-bit nibble in, 7-bit active-low pattern out. Instantiated once, fed by the active nibble of `cur`.
- The rest (`sel_q`, FSM, counter, double buffer, LZS logic, output registers) lives in the top module.

## Test plan
- Reset release, `SEL=0`, `BLANK_CYC=16` -> outputs dark for 16 cycles, then `AN=4'b1110`, `SEG=7'h40`, `DP=1`.
- `LOAD` `DATA=16'h12AF`, `DP_IN=4'b0100`, `EN_IN=4'hF`; then `SEL` stepped 1,2,3,0,1,2,3 at 100-cycle spacing:
  - `BUSY=1` until the change to 0.
  - Next frame shows: digit0 `SEG=7'h0E`, digit1 `7'h08`, digit2 `7'h24` with `DP=0`, digit3 `7'h79`.
  - 16 dark cycles precede each digit.
- `LZS=1`, `DATA=16'h0050` -> digit3 and digit2 `SEG=7'h7F`, digit1 `7'h12`, digit0 `7'h40`.
- `SEL` changes 1 then 2 five cycles apart -> blank restarts; digit2 is lit exactly 16 cycles after the second change, and digit1 is never lit.
- `LOAD` A, then `LOAD` B coincident with the change to `SEL=0` -> A is displayed this frame, `BUSY` stays 1, B is committed at the next frame start.
- `RST_N` pulsed low while digit2 is lit with `BUSY=1` -> `AN=4'hF` immediately; after release, `BUSY=0` and all digits show 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, types and hex patterns for the multiplexed 7-segment driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {BLANK, SHOW} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_buf_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_PAT[nibble];

endmodule

// File: rtl/dynamic_lighting_driver.sv
// 4-digit common-anode display multiplexer with ghost blanking, frame-aligned
// double buffering and optional leading-zero suppression.
module dynamic_lighting_driver
    import seg7_pkg::*;
#(
    parameter int unsigned BLANK_CYC = 16,
    parameter bit          LZS       = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  SEL,
    input  logic        LOAD,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  EN_IN,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        BUSY
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYC - 1);
    localparam disp_buf_t BUF_RST = '{data: 16'h0000, dp: 4'h0, en: 4'hF};

    logic [1:0]       sel_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cur;
    disp_buf_t        act;
    disp_buf_t        pend;

    logic             change;
    logic             commit;
    state_t           nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic [1:0]       nxt_cur;
    disp_buf_t        nxt_act;
    disp_buf_t        nxt_pend;
    logic             nxt_busy;
    logic [3:0]       nibble;
    logic [3:0]       lead_zero;
    logic             suppress;
    logic [6:0]       dec_seg;
    logic [3:0]       nxt_an;
    logic [6:0]       nxt_seg;
    logic             nxt_dp;

    // Decoder looks at the digit that will be shown after this edge.
    seg7_decode u_decode (
        .nibble (nibble),
        .seg_c  (dec_seg)
    );

    always_comb begin
        change    = (SEL != sel_q);
        commit    = change && (SEL == 2'd0);
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_cur   = cur;
        nxt_act   = commit ? pend : act;
        nxt_pend  = LOAD ? '{data: DATA, dp: DP_IN, en: EN_IN} : pend;
        nxt_busy  = LOAD ? 1'b1 : (commit ? 1'b0 : BUSY);

        if (change) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            nxt_cur   = SEL;
        end else if (state == BLANK) begin
            if (cnt == CNT_LAST) begin
                nxt_state = SHOW;
            end else begin
                nxt_cnt = cnt + CNT_W'(1);
            end
        end

        nibble       = 4'(nxt_act.data >> {nxt_cur, 2'b00});
        lead_zero[3] = (nxt_act.data[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (nxt_act.data[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (nxt_act.data[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
        suppress     = LZS && lead_zero[nxt_cur];

        nxt_an  = AN_OFF;
        nxt_seg = SEG_BLANK;
        nxt_dp  = 1'b1;
        if (nxt_state == SHOW && nxt_act.en[nxt_cur]) begin
            nxt_an  = ~(4'b0001 << nxt_cur);
            nxt_seg = suppress ? SEG_BLANK : dec_seg;
            nxt_dp  = ~nxt_act.dp[nxt_cur];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_q <= 2'd0;
            state <= BLANK;
            cnt   <= '0;
            cur   <= 2'd0;
            act   <= BUF_RST;
            pend  <= BUF_RST;
            BUSY  <= 1'b0;
            AN    <= AN_OFF;
            SEG   <= SEG_BLANK;
            DP    <= 1'b1;
        end else begin
            sel_q <= SEL;
            state <= nxt_state;
            cnt   <= nxt_cnt;
            cur   <= nxt_cur;
            act   <= nxt_act;
            pend  <= nxt_pend;
            BUSY  <= nxt_busy;
            AN    <= nxt_an;
            SEG   <= nxt_seg;
            DP    <= nxt_dp;
        end
    end

endmodule

// File: tb/tb_dynamic_lighting_driver.sv
// Directed bench: one DUT without and one with leading-zero suppression, same stimulus.
module tb_dynamic_lighting_driver;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    dynamic_lighting_driver #(.BLANK_CYC(16), .LZS(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .SEL(sel), .LOAD(load), .DATA(data),
        .DP_IN(dp_in), .EN_IN(en_in), .AN(an0), .SEG(seg0), .DP(dp0), .BUSY(busy0)
    );

    dynamic_lighting_driver #(.BLANK_CYC(16), .LZS(1'b1)) dut_lzs (
        .CLK(clk), .RST_N(rst_n), .SEL(sel), .LOAD(load), .DATA(data),
        .DP_IN(dp_in), .EN_IN(en_in), .AN(an1), .SEG(seg1), .DP(dp1), .BUSY(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Select digit s, expect 16 dark samples, then the lit values; pad to 100 cycles.
    task automatic show_digit(input logic [1:0] s, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp,
                              input logic [6:0] e_seg_lzs);
        sel = s;
        for (int i = 1; i <= 16; i++) begin
            step();
            load = 1'b0;
            checks++;
            if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || an1 !== 4'hF) begin
                errors++;
                $display("FAIL blank sel=%0d cyc=%0d: an=%h seg=%h dp=%b an_lzs=%h, required an=f seg=7f dp=1",
                         s, i, an0, seg0, dp0, an1);
            end
        end
        step();
        checks++;
        if (an0 !== e_an || seg0 !== e_seg || dp0 !== e_dp) begin
            errors++;
            $display("FAIL lit sel=%0d: an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                     s, an0, seg0, dp0, e_an, e_seg, e_dp);
        end
        checks++;
        if (an1 !== e_an || seg1 !== e_seg_lzs || dp1 !== e_dp) begin
            errors++;
            $display("FAIL lit_lzs sel=%0d: an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                     s, an1, seg1, dp1, e_an, e_seg_lzs, e_dp);
        end
        repeat (83) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        data  = d;
        dp_in = p;
        en_in = e;
        load  = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: busy=%b busy_lzs=%b, required 1", busy0, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 2'd0;
        load  = 1'b0;
        data  = 16'h0000;
        dp_in = 4'h0;
        en_in = 4'hF;
        #23;
        checks++;
        if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h dp=%b busy=%b, required f 7f 1 0",
                     an0, seg0, dp0, busy0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (an0 !== 4'hF || seg0 !== 7'h7F) begin
                errors++;
                $display("FAIL reset_blank cyc=%0d: an=%h seg=%h, required f 7f", i, an0, seg0);
            end
        end
        step();
        checks++;
        if (an0 !== 4'b1110 || seg0 !== 7'h40 || dp0 !== 1'b1 || seg1 !== 7'h40) begin
            errors++;
            $display("FAIL reset_first_lit: an=%h seg=%h dp=%b seg_lzs=%h, required e 40 1 40",
                     an0, seg0, dp0, seg1);
        end
        repeat (20) step();
    endtask

    task automatic test_frame();
        do_load(16'h12AF, 4'b0100, 4'hF);
        show_digit(2'd1, 4'b1101, 7'h40, 1'b1, 7'h7F);
        show_digit(2'd2, 4'b1011, 7'h40, 1'b1, 7'h7F);
        show_digit(2'd3, 4'b0111, 7'h40, 1'b1, 7'h7F);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_commit: busy=%b, required 1", busy0);
        end
        show_digit(2'd0, 4'b1110, 7'h0E, 1'b1, 7'h0E);
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_commit: busy=%b busy_lzs=%b, required 0", busy0, busy1);
        end
        show_digit(2'd1, 4'b1101, 7'h08, 1'b1, 7'h08);
        show_digit(2'd2, 4'b1011, 7'h24, 1'b0, 7'h24);
        show_digit(2'd3, 4'b0111, 7'h79, 1'b1, 7'h79);
    endtask

    task automatic test_lzs();
        do_load(16'h0050, 4'b0000, 4'hF);
        show_digit(2'd0, 4'b1110, 7'h40, 1'b1, 7'h40);
        show_digit(2'd1, 4'b1101, 7'h12, 1'b1, 7'h12);
        show_digit(2'd2, 4'b1011, 7'h40, 1'b1, 7'h7F);
        show_digit(2'd3, 4'b0111, 7'h40, 1'b1, 7'h7F);
    endtask

    task automatic test_restart();
        int lit_at;
        logic saw_d1;
        lit_at = 0;
        saw_d1 = 1'b0;
        sel = 2'd1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (an0 !== 4'hF) saw_d1 = 1'b1;
        end
        sel = 2'd2;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (an0 == 4'b1101) saw_d1 = 1'b1;
            if (lit_at == 0 && an0 == 4'b1011) lit_at = i;
        end
        checks++;
        if (saw_d1 !== 1'b0) begin
            errors++;
            $display("FAIL restart_digit1_lit: saw=%b, required 0", saw_d1);
        end
        checks++;
        if (lit_at != 17) begin
            errors++;
            $display("FAIL restart_lit_cycle: lit at sample %0d, required 17", lit_at);
        end
        checks++;
        if (seg0 !== 7'h40 || seg1 !== 7'h7F) begin
            errors++;
            $display("FAIL restart_seg: seg=%h seg_lzs=%h, required 40 7f", seg0, seg1);
        end
        repeat (70) step();
    endtask

    task automatic test_back_to_back();
        do_load(16'h4321, 4'b0000, 4'hF);
        show_digit(2'd3, 4'b0111, 7'h40, 1'b1, 7'h7F);
        data  = 16'h8765;
        dp_in = 4'b0001;
        en_in = 4'hF;
        load  = 1'b1;
        show_digit(2'd0, 4'b1110, 7'h79, 1'b1, 7'h79);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_held: busy=%b, required 1", busy0);
        end
        show_digit(2'd1, 4'b1101, 7'h24, 1'b1, 7'h24);
        show_digit(2'd2, 4'b1011, 7'h30, 1'b1, 7'h30);
        show_digit(2'd3, 4'b0111, 7'h19, 1'b1, 7'h19);
        show_digit(2'd0, 4'b1110, 7'h12, 1'b0, 7'h12);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_clear: busy=%b, required 0", busy0);
        end
        show_digit(2'd1, 4'b1101, 7'h02, 1'b1, 7'h02);
    endtask

    task automatic test_reset_mid();
        do_load(16'h9999, 4'b1111, 4'hF);
        show_digit(2'd2, 4'b1011, 7'h78, 1'b1, 7'h78);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: an=%h seg=%h dp=%b busy=%b, required f 7f 1 0",
                     an0, seg0, dp0, busy0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        show_digit(2'd2, 4'b1011, 7'h40, 1'b1, 7'h7F);
        show_digit(2'd3, 4'b0111, 7'h40, 1'b1, 7'h7F);
        show_digit(2'd0, 4'b1110, 7'h40, 1'b1, 7'h40);
        show_digit(2'd1, 4'b1101, 7'h40, 1'b1, 7'h7F);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy: busy=%b, required 0", busy0);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_lzs();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
